// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM states, wait-counter width, reserved select code and direction constants
package apb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, DONE} state_t;
  localparam int WAIT_W = 8;
  localparam int SEL_NONE = 0;
  localparam logic DIR_READ = 1'b0;
  localparam logic DIR_WRITE = 1'b1;
endpackage

// File: rtl/apb_mem_slave_p_if.sv
// apb_mem_slave_p_if: APB bus signals between a master and apb_mem_slave_p
interface apb_mem_slave_p_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int SEL_W = 2
);
  logic [SEL_W-1:0] sel;
  logic enable;
  logic write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] strb;
  logic [apb_pkg::WAIT_W-1:0] wait_cycles;
  logic ready;
  logic [DATA_W-1:0] rdata;
  logic slverr;
  modport master (output sel, enable, write, addr, wdata, strb, wait_cycles, input ready, rdata, slverr);
  modport slave (input sel, enable, write, addr, wdata, strb, wait_cycles, output ready, rdata, slverr);
endinterface

// File: rtl/apb_wait_counter.sv
// apb_wait_counter: loadable down-counter flagging the last wait cycle; never wraps below zero
module apb_wait_counter
  import apb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  input  logic [WAIT_W-1:0] load_val,
  output logic tc
);
  logic [WAIT_W-1:0] cnt;
  // load on setup, then count down while the transfer stays in its wait phase
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - WAIT_W'(1);
  assign tc = cnt == WAIT_W'(1);
endmodule

// File: rtl/apb_mem_slave_p.sv
// apb_mem_slave_p: APB slave bridging one select slot to a single-port synchronous memory; APB_MEM_SLAVE_SLVERR_EN enables slverr on addresses >= DEPTH
module apb_mem_slave_p
  import apb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int MEM_AW = 8,
  parameter int DEPTH = 256,
  parameter int SEL_W = 2,
  parameter int ID = 1
) (
  input  logic clk,
  input  logic reset,
  apb_mem_slave_p_if.slave bus,
  output logic mem_ce,
  output logic mem_wren,
  output logic mem_rden,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int BE_W = DATA_W / 8;
  state_t state, nxt;
  logic write_q, err_q, ready_q, slverr_q;
  logic [BE_W-1:0] strb_q, strb_n;
  logic sel_ok, setup, active, tc, oor, cap, wr_n, err_n, wr_done;
  assign sel_ok = ID != SEL_NONE && bus.sel == SEL_W'(ID);
  assign setup = sel_ok && !bus.enable;
  assign active = sel_ok && bus.enable;
`ifdef APB_MEM_SLAVE_SLVERR_EN
  assign oor = 32'(bus.addr) >= 32'(DEPTH);
`else
  assign oor = 1'b0;
`endif
  assign cap = state == IDLE;
  assign wr_n = cap ? bus.write : write_q;
  assign strb_n = cap ? bus.strb : strb_q;
  assign err_n = cap ? oor : err_q;
  assign wr_done = nxt == DONE && wr_n == DIR_WRITE;
  apb_wait_counter u_cnt (
    .clk(clk),
    .reset(reset),
    .load(cap && setup),
    .dec(state == WAIT && active),
    .load_val(bus.wait_cycles),
    .tc(tc)
  );
  // next state: setup capture, wait countdown, read issue, single done cycle; deselect aborts
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = !setup ? IDLE : bus.wait_cycles != '0 ? WAIT : bus.write == DIR_WRITE ? DONE : ISSUE;
      WAIT: nxt = !active ? IDLE : !tc ? WAIT : write_q == DIR_WRITE ? DONE : ISSUE;
      ISSUE: nxt = active ? DONE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // state, captured transfer and registered strobes decoded from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      write_q <= 1'b0;
      err_q <= 1'b0;
      strb_q <= '0;
      ready_q <= 1'b0;
      slverr_q <= 1'b0;
      mem_ce <= 1'b0;
      mem_wren <= 1'b0;
      mem_rden <= 1'b0;
      mem_be <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= nxt;
      ready_q <= nxt == DONE;
      slverr_q <= nxt == DONE && err_n;
      mem_wren <= wr_done && !err_n;
      mem_rden <= nxt == ISSUE && !err_n;
      mem_ce <= (wr_done || nxt == ISSUE) && !err_n;
      mem_be <= err_n ? '0 : nxt == ISSUE ? '1 : wr_done ? strb_n : '0;
      if (cap && setup) begin
        write_q <= bus.write;
        strb_q <= bus.strb;
        err_q <= oor;
        mem_addr <= bus.addr[MEM_AW-1:0];
        mem_wdata <= bus.wdata;
      end
    end
  end
  assign bus.ready = ready_q;
  assign bus.slverr = slverr_q;
  assign bus.rdata = state == DONE && write_q == DIR_READ && !err_q ? mem_rdata : '0;
endmodule

// File: tb/tb_apb_mem_slave_p.sv
// tb_apb_mem_slave_p: scoreboard bench for apb_mem_slave_p with 32-bit data, ID 2, DEPTH 200
module tb_apb_mem_slave_p;
  localparam int DEPTH = 200;
  localparam logic [1:0] ID = 2'd2;
`ifdef APB_MEM_SLAVE_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif
  typedef struct {
    int ready_at;
    int wren_cnt;
    int rden_at;
    logic [3:0] be;
    logic [31:0] rdata;
    logic slverr;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem_ce, mem_wren, mem_rden;
  logic [3:0] mem_be;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [256] = '{default: '0};
  logic [31:0] model [256] = '{default: '0};
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int o_ready_at, o_wren_cnt, o_wren_at, o_rden_at, o_any;
  logic [3:0] o_be;
  logic [7:0] o_addr;
  logic [31:0] o_wdata, o_rdata;
  logic o_slverr;

  apb_mem_slave_p_if #(.DATA_W(32), .ADDR_W(8), .SEL_W(2)) bus ();

  apb_mem_slave_p #(
    .DATA_W(32), .ADDR_W(8), .MEM_AW(8), .DEPTH(DEPTH), .SEL_W(2), .ID(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .mem_ce(mem_ce),
    .mem_wren(mem_wren),
    .mem_rden(mem_rden),
    .mem_be(mem_be),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_ce && mem_wren)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    if (mem_ce && mem_rden) mem_rdata <= mem[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_exp(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input logic [7:0] w);
    exp_t e;
    logic oor;
    oor = SLVERR_EN && int'(a) >= DEPTH;
    e.ready_at = int'(w) + (wr ? 1 : 2);
    e.wren_cnt = (wr && !oor) ? 1 : 0;
    e.rden_at = (!wr && !oor) ? int'(w) + 1 : 0;
    e.be = wr ? s : 4'hf;
    e.rdata = (wr || oor) ? 32'h0 : model[a];
    e.slverr = oor;
    if (wr && !oor)
      for (int i = 0; i < 4; i++)
        if (s[i]) model[a][8*i +: 8] = d[8*i +: 8];
    sb.push_back(e);
  endtask

  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input logic [7:0] w, input logic [1:0] sl, input int lim);
    o_ready_at = 0; o_wren_cnt = 0; o_wren_at = 0; o_rden_at = 0; o_any = 0;
    o_be = 'x; o_addr = 'x; o_wdata = 'x; o_rdata = 'x; o_slverr = 'x;
    @(posedge clk); #1;
    bus.sel = sl; bus.enable = 1'b0; bus.write = wr; bus.addr = a;
    bus.wdata = d; bus.strb = s; bus.wait_cycles = w;
    @(posedge clk); #1;
    bus.enable = 1'b1;
    for (int n = 1; n <= lim; n++) begin
      @(negedge clk);
      if (bus.ready || bus.slverr || mem_ce || mem_wren || mem_rden || mem_be != 0 || mem_addr != 0 || mem_wdata != 0 || bus.rdata != 0) o_any++;
      if (mem_wren) begin o_wren_cnt++; o_wren_at = n; o_be = mem_be; o_addr = mem_addr; o_wdata = mem_wdata; end
      if (mem_rden) begin o_rden_at = n; o_be = mem_be; o_addr = mem_addr; end
      if (bus.ready) begin o_ready_at = n; o_rdata = bus.rdata; o_slverr = bus.slverr; break; end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    bus.sel = 2'd0; bus.enable = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.sel = 2'd0; bus.enable = 1'b0; bus.write = 1'b0; bus.addr = '0;
    bus.wdata = '0; bus.strb = '0; bus.wait_cycles = '0;
    repeat (3) @(posedge clk); #1;
    total++;
    if ({bus.ready, bus.slverr, mem_ce, mem_wren, mem_rden} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes: got %b want 00000", {bus.ready, bus.slverr, mem_ce, mem_wren, mem_rden});
    end
    total++;
    if ({mem_be, mem_addr, mem_wdata, bus.rdata} !== 76'h0) begin
      bad++; $display("FAIL reset_data: be=%h addr=%h wdata=%h rdata=%h want all 0", mem_be, mem_addr, mem_wdata, bus.rdata);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_select();
    xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'hf, 8'd0, 2'd1, 6);
    total++;
    if (o_ready_at !== 0) begin bad++; $display("FAIL select_ready: got cycle %0d want none", o_ready_at); end
    total++;
    if (o_any !== 0) begin bad++; $display("FAIL select_quiet: got %0d active cycles want 0", o_any); end
    idle(1);
  endtask

  task automatic test_write_w0();
    exp_t e;
    push_exp(1'b1, 8'h10, 32'h000000A5, 4'b0001, 8'd0);
    xfer(1'b1, 8'h10, 32'h000000A5, 4'b0001, 8'd0, ID, 20);
    e = sb.pop_front();
    total++;
    if (o_ready_at !== e.ready_at) begin bad++; $display("FAIL w0_ready: got %0d want %0d", o_ready_at, e.ready_at); end
    total++;
    if (o_wren_at !== 1 || o_wren_cnt !== e.wren_cnt) begin bad++; $display("FAIL w0_wren: got at %0d cnt %0d want at 1 cnt %0d", o_wren_at, o_wren_cnt, e.wren_cnt); end
    total++;
    if (o_addr !== 8'h10 || o_wdata !== 32'hA5 || o_be !== e.be) begin bad++; $display("FAIL w0_mem: got addr %h data %h be %b want 10 a5 %b", o_addr, o_wdata, o_be, e.be); end
    idle(1);
  endtask

  task automatic test_read_w3();
    exp_t e;
    push_exp(1'b0, 8'h10, 32'h0, 4'h0, 8'd3);
    xfer(1'b0, 8'h10, 32'h0, 4'h0, 8'd3, ID, 20);
    e = sb.pop_front();
    total++;
    if (o_rden_at !== e.rden_at || o_be !== e.be) begin bad++; $display("FAIL r3_rden: got at %0d be %b want at %0d be %b", o_rden_at, o_be, e.rden_at, e.be); end
    total++;
    if (o_ready_at !== e.ready_at) begin bad++; $display("FAIL r3_ready: got %0d want %0d", o_ready_at, e.ready_at); end
    total++;
    if (o_rdata !== e.rdata || o_slverr !== e.slverr) begin bad++; $display("FAIL r3_data: got %h err %b want %h err %b", o_rdata, o_slverr, e.rdata, e.slverr); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic wr;
    logic [7:0] a, w;
    logic [31:0] d;
    logic [3:0] s;
    push_exp(1'b1, 8'h20, 32'h11223344, 4'b0101, 8'd1);
    xfer(1'b1, 8'h20, 32'h11223344, 4'b0101, 8'd1, ID, 20);
    e = sb.pop_front();
    total++;
    if (o_be !== e.be || o_wren_cnt !== e.wren_cnt || o_ready_at !== e.ready_at) begin bad++; $display("FAIL b2b_write: got be %b cnt %0d rdy %0d want be %b cnt %0d rdy %0d", o_be, o_wren_cnt, o_ready_at, e.be, e.wren_cnt, e.ready_at); end
    push_exp(1'b0, 8'h20, 32'h0, 4'h0, 8'd0);
    xfer(1'b0, 8'h20, 32'h0, 4'h0, 8'd0, ID, 20);
    e = sb.pop_front();
    total++;
    if (o_be !== e.be || o_rdata !== e.rdata || o_ready_at !== e.ready_at || o_wren_cnt !== 0) begin bad++; $display("FAIL b2b_read: got be %b data %h rdy %0d wren %0d want be %b data %h rdy %0d wren 0", o_be, o_rdata, o_ready_at, o_wren_cnt, e.be, e.rdata, e.ready_at); end
    push_exp(1'b1, 8'h20, 32'hFFFFFFFF, 4'b0000, 8'd0);
    xfer(1'b1, 8'h20, 32'hFFFFFFFF, 4'b0000, 8'd0, ID, 20);
    e = sb.pop_front();
    total++;
    if (o_be !== 4'b0000 || o_wren_cnt !== 1 || o_ready_at !== e.ready_at) begin bad++; $display("FAIL strb0_write: got be %b cnt %0d rdy %0d want be 0000 cnt 1 rdy %0d", o_be, o_wren_cnt, o_ready_at, e.ready_at); end
    push_exp(1'b0, 8'h20, 32'h0, 4'h0, 8'd0);
    xfer(1'b0, 8'h20, 32'h0, 4'h0, 8'd0, ID, 20);
    e = sb.pop_front();
    total++;
    if (o_rdata !== e.rdata) begin bad++; $display("FAIL strb0_read: got %h want %h", o_rdata, e.rdata); end
    for (int k = 0; k < 10; k++) begin
      wr = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 15) * 4);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      w = 8'($urandom_range(0, 3));
      push_exp(wr, a, d, s, w);
      xfer(wr, a, d, s, w, ID, 20);
      e = sb.pop_front();
      total++;
      if (o_ready_at !== e.ready_at || o_wren_cnt !== e.wren_cnt || o_rden_at !== e.rden_at || o_be !== e.be) begin
        bad++; $display("FAIL rand_timing[%0d]: got rdy %0d wren %0d rden %0d be %b want %0d %0d %0d %b", k, o_ready_at, o_wren_cnt, o_rden_at, o_be, e.ready_at, e.wren_cnt, e.rden_at, e.be);
      end
      if (!wr) begin
        total++;
        if (o_rdata !== e.rdata) begin bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", k, o_rdata, e.rdata); end
      end
    end
    idle(1);
  endtask

  task automatic test_abort();
    exp_t e;
    int wr_seen = 0;
    int rdy_seen = 0;
    @(posedge clk); #1;
    bus.sel = ID; bus.enable = 1'b0; bus.write = 1'b1; bus.addr = 8'h30;
    bus.wdata = 32'hCAFEF00D; bus.strb = 4'hf; bus.wait_cycles = 8'd5;
    @(posedge clk); #1;
    bus.enable = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      if (n == 3) bus.sel = 2'd0;
      @(negedge clk);
      wr_seen += int'(mem_wren);
      rdy_seen += int'(bus.ready);
      @(posedge clk); #1;
    end
    bus.enable = 1'b0;
    total++;
    if (wr_seen !== 0 || rdy_seen !== 0) begin bad++; $display("FAIL abort: got wren %0d ready %0d want 0 0", wr_seen, rdy_seen); end
    push_exp(1'b0, 8'h30, 32'h0, 4'h0, 8'd0);
    xfer(1'b0, 8'h30, 32'h0, 4'h0, 8'd0, ID, 20);
    e = sb.pop_front();
    total++;
    if (o_rdata !== e.rdata || o_ready_at !== e.ready_at) begin bad++; $display("FAIL abort_readback: got %h rdy %0d want %h rdy %0d", o_rdata, o_ready_at, e.rdata, e.ready_at); end
    idle(1);
  endtask

  task automatic test_out_of_range();
    exp_t e;
    push_exp(1'b1, 8'hF0, 32'h5A5A5A5A, 4'hf, 8'd1);
    xfer(1'b1, 8'hF0, 32'h5A5A5A5A, 4'hf, 8'd1, ID, 20);
    e = sb.pop_front();
    total++;
    if (o_ready_at !== e.ready_at || o_slverr !== e.slverr || o_wren_cnt !== e.wren_cnt) begin bad++; $display("FAIL oor_write: got rdy %0d err %b wren %0d want %0d %b %0d", o_ready_at, o_slverr, o_wren_cnt, e.ready_at, e.slverr, e.wren_cnt); end
    push_exp(1'b0, 8'hF0, 32'h0, 4'h0, 8'd1);
    xfer(1'b0, 8'hF0, 32'h0, 4'h0, 8'd1, ID, 20);
    e = sb.pop_front();
    total++;
    if (o_ready_at !== e.ready_at || o_slverr !== e.slverr || o_rden_at !== e.rden_at) begin bad++; $display("FAIL oor_read: got rdy %0d err %b rden %0d want %0d %b %0d", o_ready_at, o_slverr, o_rden_at, e.ready_at, e.slverr, e.rden_at); end
    total++;
    if (o_rdata !== e.rdata) begin bad++; $display("FAIL oor_rdata: got %h want %h", o_rdata, e.rdata); end
`ifndef APB_MEM_SLAVE_SLVERR_EN
    total++;
    if (o_addr !== 8'hF0) begin bad++; $display("FAIL oor_addr: got %h want f0", o_addr); end
`endif
    idle(1);
  endtask

  task automatic test_long_wait();
    exp_t e;
    push_exp(1'b1, 8'h50, 32'h0BADF00D, 4'hf, 8'd255);
    xfer(1'b1, 8'h50, 32'h0BADF00D, 4'hf, 8'd255, ID, 300);
    e = sb.pop_front();
    total++;
    if (o_ready_at !== e.ready_at || o_wren_at !== e.ready_at || o_wren_cnt !== e.wren_cnt) begin bad++; $display("FAIL wait255: got rdy %0d wren at %0d cnt %0d want %0d %0d %0d", o_ready_at, o_wren_at, o_wren_cnt, e.ready_at, e.ready_at, e.wren_cnt); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int seen = 0;
    @(posedge clk); #1;
    bus.sel = ID; bus.enable = 1'b0; bus.write = 1'b1; bus.addr = 8'h44;
    bus.wdata = 32'h12345678; bus.strb = 4'hf; bus.wait_cycles = 8'd4;
    @(posedge clk); #1;
    bus.enable = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    total++;
    if ({bus.ready, bus.slverr, mem_ce, mem_wren, mem_rden} !== 5'b0) begin bad++; $display("FAIL midreset_strobes: got %b want 00000", {bus.ready, bus.slverr, mem_ce, mem_wren, mem_rden}); end
    total++;
    if ({mem_be, mem_addr, mem_wdata, bus.rdata} !== 76'h0) begin bad++; $display("FAIL midreset_data: be=%h addr=%h wdata=%h rdata=%h want all 0", mem_be, mem_addr, mem_wdata, bus.rdata); end
    repeat (3) begin
      @(negedge clk);
      seen += int'(mem_wren) + int'(bus.ready);
    end
    bus.sel = 2'd0; bus.enable = 1'b0;
    reset = 1'b1;
    total++;
    if (seen !== 0) begin bad++; $display("FAIL midreset_quiet: got %0d strobes want 0", seen); end
    push_exp(1'b0, 8'h44, 32'h0, 4'h0, 8'd0);
    xfer(1'b0, 8'h44, 32'h0, 4'h0, 8'd0, ID, 20);
    e = sb.pop_front();
    total++;
    if (o_rdata !== e.rdata || o_ready_at !== e.ready_at) begin bad++; $display("FAIL midreset_nowrite: got %h rdy %0d want %h rdy %0d", o_rdata, o_ready_at, e.rdata, e.ready_at); end
    push_exp(1'b1, 8'h44, 32'h87654321, 4'hf, 8'd2);
    xfer(1'b1, 8'h44, 32'h87654321, 4'hf, 8'd2, ID, 20);
    e = sb.pop_front();
    total++;
    if (o_ready_at !== e.ready_at || o_wren_cnt !== e.wren_cnt || o_addr !== 8'h44) begin bad++; $display("FAIL midreset_fresh: got rdy %0d wren %0d addr %h want %0d %0d 44", o_ready_at, o_wren_cnt, o_addr, e.ready_at, e.wren_cnt); end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_select();
    test_write_w0();
    test_read_w3();
    test_back_to_back();
    test_abort();
    test_out_of_range();
    test_long_wait();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
